// File: rtl/sd_buf_pkg.sv
// Shared types and constants for the SD sector buffer: FSM encoding, sector geometry
// and the default request timeout.
package sd_buf_pkg;

    localparam int          SECTOR_BYTES    = 512;
    localparam int          BUF_ADDR_W      = 9;
    localparam logic [23:0] DEFAULT_TIMEOUT = 24'd12000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        FIN  = 2'd3
    } sd_state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// 512x8 dual-port synchronous RAM: port A serves the core, port B serves user I/O.
// Port B read register only loads when b_re is high so its output holds between strobes.
module sd_sector_ram #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [7:0]        b_wdata,
    input  logic              b_re,
    output logic [7:0]        b_rdata
);

    logic [7:0] mem [2**ADDR_W];

    // The two write ports are never active together: core writes are blocked while busy.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
        a_rdata <= mem[a_addr];
        if (b_re) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/sd_sector_buffer.sv
// Single-sector block front end toward the SPI user I/O SD interface.
// Optional SD_SECTOR_SUM_EN adds blk_sum, the 16-bit sum of bytes moved in the last transfer.
module sd_sector_buffer
    import sd_buf_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = DEFAULT_TIMEOUT,
    parameter int          ADDR_W  = BUF_ADDR_W
) (
    input  logic              clk_sd,
    input  logic              reset,
    input  logic [31:0]       blk_lba,
    input  logic              blk_rd,
    input  logic              blk_wr,
    output logic              blk_busy,
    output logic              blk_done,
    output logic              blk_err,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_wdata,
    input  logic              core_we,
    output logic [7:0]        core_rdata,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [7:0]        sd_dout,
    input  logic              sd_dout_strobe,
    output logic [7:0]        sd_din,
    input  logic              sd_din_strobe,
    input  logic [ADDR_W-1:0] sd_buff_addr,
`ifdef SD_SECTOR_SUM_EN
    output logic [15:0]       blk_sum,
`endif
    output sd_state_t         fsm_state
);

    localparam logic [9:0] FULL_CNT = 10'(SECTOR_BYTES);

    if (ADDR_W != BUF_ADDR_W) begin : g_bad_addr_w
        $error("sd_sector_buffer: ADDR_W must be 9");
    end

    sd_state_t   state, state_nxt;
    logic        ack_q;
    logic        ack_rise, ack_fall;
    logic [23:0] tmr;
    logic        tmo_hit;
    logic [9:0]  cnt, cnt_inc;
    logic        req_go;
    logic        ram_a_we, ram_b_we, ram_b_re;
    logic [7:0]  ram_a_q, ram_b_q;
    logic        rd_valid, din_valid;

    // Handshake: sd_rd/sd_wr stay high until a fresh sd_ack rise; the transfer
    // lasts while sd_ack stays high and ends on its falling edge.
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign tmo_hit  = (TIMEOUT != 24'd0) && (tmr == TIMEOUT - 24'd1);
    assign req_go   = blk_rd | blk_wr;
    assign ram_a_we = core_we & ~blk_busy;
    assign ram_b_we = sd_dout_strobe & (state == XFER);
    assign ram_b_re = sd_din_strobe & (state == XFER);
    assign cnt_inc  = ((ram_b_we | ram_b_re) && cnt != FULL_CNT) ? cnt + 10'd1 : cnt;

    always_ff @(posedge clk_sd or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_go) state_nxt = REQ;
            REQ: begin
                if (ack_rise)     state_nxt = XFER;
                else if (tmo_hit) state_nxt = FIN;
            end
            XFER: if (ack_fall) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        blk_busy  = (state != IDLE);
        blk_done  = (state == FIN);
        fsm_state = state;
    end

    always_ff @(posedge clk_sd or posedge reset) begin
        if (reset) begin
            sd_lba    <= 32'd0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            blk_err   <= 1'b0;
            cnt       <= 10'd0;
            tmr       <= 24'd0;
            ack_q     <= 1'b0;
            rd_valid  <= 1'b0;
            din_valid <= 1'b0;
        end else begin
            ack_q    <= sd_ack;
            rd_valid <= 1'b1;
            if (ram_b_re) din_valid <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_go) begin
                        sd_lba  <= blk_lba;
                        sd_rd   <= blk_rd;
                        sd_wr   <= ~blk_rd;
                        blk_err <= 1'b0;
                        tmr     <= 24'd0;
                        cnt     <= 10'd0;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end else if (tmo_hit) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        blk_err <= 1'b1;
                    end else begin
                        tmr <= tmr + 24'd1;
                    end
                end
                XFER: begin
                    cnt <= cnt_inc;
                    if (ack_fall && cnt_inc != FULL_CNT) blk_err <= 1'b1;
                end
                FIN: cnt <= 10'd0;
                default: cnt <= 10'd0;
            endcase
        end
    end

    // RAM outputs are masked until they hold defined data so every output reads 0 after reset.
    assign core_rdata = rd_valid  ? ram_a_q : 8'd0;
    assign sd_din     = din_valid ? ram_b_q : 8'd0;

    sd_sector_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk_sd),
        .a_addr  (core_addr),
        .a_we    (ram_a_we),
        .a_wdata (core_wdata),
        .a_rdata (ram_a_q),
        .b_addr  (sd_buff_addr),
        .b_we    (ram_b_we),
        .b_wdata (sd_dout),
        .b_re    (ram_b_re),
        .b_rdata (ram_b_q)
    );

`ifdef SD_SECTOR_SUM_EN
    logic        din_pend;
    logic [15:0] sum_q;

    // A din byte is only visible one cycle after its strobe, so it is summed a cycle late.
    always_ff @(posedge clk_sd or posedge reset) begin
        if (reset) begin
            din_pend <= 1'b0;
            sum_q    <= 16'd0;
        end else begin
            din_pend <= ram_b_re;
            if (state == IDLE && req_go)
                sum_q <= 16'd0;
            else
                sum_q <= sum_q + (ram_b_we ? {8'd0, sd_dout} : 16'd0)
                               + (din_pend ? {8'd0, ram_b_q} : 16'd0);
        end
    end

    assign blk_sum = sum_q;
`endif

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: directed vector table, hand sequences for the
// multi-cycle corners, and randomized transfers checked against an array model of the sector.
module tb_sd_sector_buffer;
    import sd_buf_pkg::*;

    logic        clk_sd = 1'b0;
    logic        reset;
    logic [31:0] blk_lba;
    logic        blk_rd, blk_wr;
    logic        blk_busy, blk_done, blk_err;
    logic [8:0]  core_addr;
    logic [7:0]  core_wdata;
    logic        core_we;
    logic [7:0]  core_rdata;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_dout, sd_din;
    logic        sd_dout_strobe, sd_din_strobe;
    logic [8:0]  sd_buff_addr;
    sd_state_t   fsm_state;
`ifdef SD_SECTOR_SUM_EN
    logic [15:0] blk_sum;
`endif

    always #5 clk_sd = ~clk_sd;

    sd_sector_buffer #(.TIMEOUT(24'd16)) dut (
        .clk_sd         (clk_sd),
        .reset          (reset),
        .blk_lba        (blk_lba),
        .blk_rd         (blk_rd),
        .blk_wr         (blk_wr),
        .blk_busy       (blk_busy),
        .blk_done       (blk_done),
        .blk_err        (blk_err),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_we        (core_we),
        .core_rdata     (core_rdata),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_dout        (sd_dout),
        .sd_dout_strobe (sd_dout_strobe),
        .sd_din         (sd_din),
        .sd_din_strobe  (sd_din_strobe),
        .sd_buff_addr   (sd_buff_addr),
`ifdef SD_SECTOR_SUM_EN
        .blk_sum        (blk_sum),
`endif
        .fsm_state      (fsm_state)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_mem [512];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [8:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic tick();
        @(posedge clk_sd);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic request(input logic rd, input logic wr, input logic [31:0] lba);
        blk_rd  = rd;
        blk_wr  = wr;
        blk_lba = lba;
        tick();
        blk_rd  = 1'b0;
        blk_wr  = 1'b0;
        blk_lba = $urandom;
    endtask

    task automatic start(input logic rd, input logic wr, input logic [31:0] lba, input string tag);
        request(rd, wr, lba);
        check({tag, " sd_rd"}, sd_rd, rd);
        check({tag, " sd_wr"}, sd_wr, !rd);
        check({tag, " sd_lba"}, sd_lba, lba);
        check({tag, " busy"}, blk_busy, 1);
        check({tag, " err_clear"}, blk_err, 0);
        check({tag, " state_req"}, fsm_state, REQ);
    endtask

    task automatic ack_up(input string tag);
        sd_ack = 1'b1;
        tick();
        check({tag, " req_dropped"}, {sd_rd, sd_wr}, 2'b00);
        check({tag, " state_xfer"}, fsm_state, XFER);
    endtask

    task automatic wait_done(input logic exp_err, input string tag);
        int   pulses = 0;
        logic err_at = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (blk_done) begin
                pulses++;
                err_at = blk_err;
            end
        end
        check({tag, " done_pulses"}, pulses, 1);
        check({tag, " err"}, err_at, exp_err);
        check({tag, " busy_after"}, blk_busy, 0);
    endtask

    task automatic dout_burst(input int n, input bit rnd);
        logic [8:0] a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            a = rnd ? 9'($urandom_range(0, 511)) : 9'(i);
            d = rnd ? 8'($urandom) : (a[7:0] ^ 8'hA5);
            sd_buff_addr   = a;
            sd_dout        = d;
            sd_dout_strobe = 1'b1;
            model_mem[a]   = d;
            tick();
        end
        sd_dout_strobe = 1'b0;
    endtask

    task automatic din_burst(input int n, input bit rnd, input bit poke);
        logic [8:0] a;
        for (int i = 0; i < n; i++) begin
            a = rnd ? 9'($urandom_range(0, 511)) : 9'(i);
            exp_q.push_back(model_mem[a]);
            sd_buff_addr  = a;
            sd_din_strobe = 1'b1;
            if (poke) begin
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = 9'($urandom_range(0, 511));
                core_wdata = 8'($urandom);
            end
            tick();
            check("sd_din", sd_din, exp_q.pop_front());
        end
        sd_din_strobe = 1'b0;
        core_we       = 1'b0;
    endtask

    task automatic core_write(input logic [8:0] a, input logic [7:0] d);
        core_addr  = a;
        core_wdata = d;
        core_we    = 1'b1;
        tick();
        core_we      = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic core_read(input logic [8:0] a, input string tag);
        core_addr = a;
        core_we   = 1'b0;
        tick();
        check(tag, core_rdata, model_mem[a]);
    endtask

    initial begin
        int         n;
        logic [31:0] lba;
        logic [7:0]  keep0;

        reset = 1'b1;
        blk_lba = '0; blk_rd = 0; blk_wr = 0;
        core_addr = '0; core_wdata = '0; core_we = 0;
        sd_ack = 0; sd_dout = '0; sd_dout_strobe = 0; sd_din_strobe = 0; sd_buff_addr = '0;
        repeat (3) tick();
        check("rst busy", blk_busy, 0);
        check("rst done", blk_done, 0);
        check("rst err", blk_err, 0);
        check("rst sd_lba", sd_lba, 0);
        check("rst sd_rdwr", {sd_rd, sd_wr}, 2'b00);
        check("rst sd_din", sd_din, 0);
        check("rst core_rdata", core_rdata, 0);
        check("rst state", fsm_state, IDLE);
        reset = 1'b0;
        tick();

        // Full read sector: data = addr ^ A5
        start(1, 0, 32'h0000_1234, "read");
        ack_up("read");
        dout_burst(512, 0);
        sd_ack = 1'b0;
        wait_done(0, "read");
        core_read(9'h005, "read rdata_005");

        // Core port vectors against the sector just read
        vecs[0]  = '{9'h005, 8'h00, 1'b0, 8'hA0};
        vecs[1]  = '{9'h1FF, 8'h00, 1'b0, 8'h5A};
        vecs[2]  = '{9'h100, 8'h00, 1'b0, 8'hA5};
        vecs[3]  = '{9'h0AA, 8'h00, 1'b0, 8'h0F};
        vecs[4]  = '{9'h003, 8'h3C, 1'b1, 8'h00};
        vecs[5]  = '{9'h003, 8'h00, 1'b0, 8'h3C};
        vecs[6]  = '{9'h1FF, 8'hC3, 1'b1, 8'h00};
        vecs[7]  = '{9'h1FF, 8'h00, 1'b0, 8'hC3};
        vecs[8]  = '{9'h005, 8'h00, 1'b0, 8'hA0};
        vecs[9]  = '{9'h100, 8'h00, 1'b1, 8'h00};
        vecs[10] = '{9'h100, 8'h00, 1'b0, 8'h00};
        for (int i = 0; i < 11; i++) begin
            core_addr  = vecs[i].addr;
            core_wdata = vecs[i].wdata;
            core_we    = vecs[i].we;
            tick();
            if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].wdata;
            else check($sformatf("vec%0d rdata", i), core_rdata, vecs[i].exp);
        end
        core_we = 1'b0;

        // Write sector: buffer[i] = i[7:0], drained as 00..FF twice
        for (int i = 0; i < 512; i++) core_write(9'(i), 8'(i));
        start(0, 1, 32'h0000_0042, "write");
        ack_up("write");
        din_burst(512, 0, 0);
        sd_ack = 1'b0;
        wait_done(0, "write");

        // Short transfer; rd+wr together selects read; requests while busy are ignored
        start(1, 1, 32'h0000_0777, "short");
        ack_up("short");
        blk_wr  = 1'b1;
        blk_lba = 32'hDEAD_BEEF;
        tick();
        blk_wr = 1'b0;
        check("busy_ignore sd_lba", sd_lba, 32'h0000_0777);
        check("busy_ignore sd_wr", sd_wr, 0);
        dout_burst(100, 1);
        sd_ack = 1'b0;
        wait_done(1, "short");

        // Timeout with no ack
        start(1, 0, 32'h0000_0099, "tmo");
        n = 0;
        while (sd_rd && n < 40) begin
            n++;
            tick();
        end
        check("tmo req_cycles", n, 16);
        check("tmo done", blk_done, 1);
        check("tmo err", blk_err, 1);
        tick();
        check("tmo done_once", blk_done, 0);
        check("tmo busy_after", blk_busy, 0);

        // Stale ack, then core write protection during XFER
        sd_ack = 1'b1;
        repeat (2) tick();
        start(1, 0, 32'h0000_0055, "stale");
        repeat (4) tick();
        check("stale hold_state", fsm_state, REQ);
        check("stale hold_rd", sd_rd, 1);
        sd_ack = 1'b0;
        repeat (2) tick();
        check("stale low_state", fsm_state, REQ);
        ack_up("stale");
        keep0      = model_mem[0];
        core_addr  = 9'h000;
        core_wdata = ~keep0;
        core_we    = 1'b1;
        tick();
        core_we = 1'b0;
        sd_ack  = 1'b0;
        wait_done(1, "stale");
        core_read(9'h000, "protect addr0");

        // Reset in the middle of a transfer
        start(1, 0, 32'h0000_0AAA, "rstmid");
        ack_up("rstmid");
        dout_burst(200, 0);
        reset = 1'b1;
        #1;
        check("rstmid busy", blk_busy, 0);
        check("rstmid sd_rdwr", {sd_rd, sd_wr}, 2'b00);
        check("rstmid sd_lba", sd_lba, 0);
        check("rstmid err", blk_err, 0);
        check("rstmid sd_din", sd_din, 0);
        check("rstmid core_rdata", core_rdata, 0);
        check("rstmid state", fsm_state, IDLE);
        sd_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstmid no_done", blk_done, 0);
        end
        reset = 1'b0;
        tick();
        check("rstmid no_done_after", blk_done, 0);
        start(1, 0, 32'h0000_0BBB, "after_rst");
        ack_up("after_rst");
        dout_burst(512, 0);
        sd_ack = 1'b0;
        wait_done(0, "after_rst");
        core_read(9'h005, "after_rst rdata_005");

        // Randomized transfers against the array model
        for (int r = 0; r < 8; r++) begin
            lba = $urandom;
            n   = ($urandom_range(0, 1) != 0) ? 512 : int'($urandom_range(1, 600));
            if ($urandom_range(0, 1) != 0) begin
                start(1, 0, lba, "rnd_rd");
                ack_up("rnd_rd");
                dout_burst(n, 1);
                sd_ack = 1'b0;
                wait_done(n < 512, "rnd_rd");
                for (int k = 0; k < 4; k++) core_read(9'($urandom_range(0, 511)), "rnd_rd rdata");
            end else begin
                for (int k = 0; k < 8; k++) core_write(9'($urandom_range(0, 511)), 8'($urandom));
                start(0, 1, lba, "rnd_wr");
                ack_up("rnd_wr");
                din_burst(n, 1, 1);
                sd_ack = 1'b0;
                wait_done(n < 512, "rnd_wr");
            end
        end

        // Full buffer sweep
        for (int i = 0; i < 512; i++) core_read(9'(i), "sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
Core-side block-device front end on the clk_sd domain, directly downstream of the SPI user I/O block's SD interface. Accepts single-sector read/write requests from core logic and drives sd_lba/sd_rd/sd_wr toward user I/O. Owns the 512-byte sector RAM that user I/O fills via sd_dout_strobe and drains via sd_din_strobe. Gives the core a byte-addressed buffer port plus busy/done/error status.

Parameters:
TIMEOUT, 24'd12000000, clk_sd cycles to wait for sd_ack rise after a request; 0 disables the timeout.
ADDR_W, 9, buffer address width (512 bytes); fixed and checked at elaboration.

Ports:
clk_sd  in  1  sole clock
reset  in  1  asynchronous, active-high
blk_lba  in  32  sector number, sampled with blk_rd/blk_wr
blk_rd  in  1  one-cycle read request pulse
blk_wr  in  1  one-cycle write request pulse
blk_busy  out  1  request in progress
blk_done  out  1  one-cycle completion pulse
blk_err  out  1  sticky error flag; cleared by next accepted request
core_addr  in  9  core buffer address
core_wdata  in  8  core write data
core_we  in  1  core write enable
core_rdata  out  8  buffer[core_addr], 1-cycle latency
sd_lba  out  32  latched LBA to user I/O
sd_rd  out  1  read request to user I/O
sd_wr  out  1  write request to user I/O
sd_ack  in  1  transfer acknowledge from user I/O
sd_dout  in  8  received byte
sd_dout_strobe  in  1  sd_dout valid, write buffer[sd_buff_addr]
sd_din  out  8  byte to user I/O
sd_din_strobe  in  1  load sd_din from buffer[sd_buff_addr]
sd_buff_addr  in  9  user I/O byte pointer

Behaviour:
- Reset values: all outputs 0, FSM IDLE, byte counter 0, sd_lba 0. Buffer contents undefined.
- FSM states: IDLE, REQ, XFER, FIN.
- IDLE: blk_rd or blk_wr latches blk_lba into sd_lba, clears blk_err, sets blk_busy, and asserts sd_rd or sd_wr on the next cycle. Next state REQ.
  - blk_rd and blk_wr together: read wins.
  - Requests while busy are ignored.
- REQ: hold sd_rd/sd_wr until sd_ack is seen high, then deassert both and go to XFER.
  - If TIMEOUT cycles pass without ack: deassert the request, set blk_err, go to FIN.
- XFER: every sd_dout_strobe writes sd_dout to buffer[sd_buff_addr] and increments the byte counter.
  - Every sd_din_strobe registers buffer[sd_buff_addr] into sd_din the next cycle and increments the byte counter.
  - Counter saturates at 512.
  - When sd_ack falls, go to FIN. If counter != 512, set blk_err.
- FIN: pulse blk_done for one cycle, clear blk_busy, reset counter, return to IDLE. Request-accept to blk_busy latency is 1 cycle.
- Core port:
  - core_rdata is always valid with 1-cycle latency.
  - core_we is ignored while blk_busy=1. Write protection: a sector cannot be corrupted mid-transfer.
  - Core reads during a read XFER return partially updated data; this is legal.
- Same-cycle sd_dout_strobe and core_we to the same address: impossible, since core writes are blocked while busy.
- sd_ack already high on entry to REQ (stale ack): ignored. REQ requires a fresh low-to-high edge.
- Reset mid-transfer: FSM goes to IDLE, request lines drop, no blk_done is issued.
- Buffer RAM: true dual-port, one port per side, both on clk_sd, synchronous read.

Optional Feature:
SD_SECTOR_SUM_EN:
- Defined: adds output blk_sum[15:0], the modulo-2^16 sum of all bytes moved in the last transfer (dout or din). Cleared on request accept; valid when blk_done pulses.
- Undefined: port absent, no adder logic.

Decomposition:
- Shared package sd_buf_pkg:
  - FSM state enum (IDLE/REQ/XFER/FIN)
  - SECTOR_BYTES=512
  - BUF_ADDR_W=9
  - default TIMEOUT constant
- One sub-module: sd_sector_ram, a 512x8 true dual-port synchronous RAM, inferable.

Test Plan:
- Read: blk_rd with blk_lba=32'h00001234 -> sd_lba=32'h1234 and sd_rd=1 next cycle. Model raises sd_ack, then 512 dout strobes of data addr^8'hA5 with sd_buff_addr 0..511, drops ack -> one blk_done pulse, blk_err=0, core_rdata at 9'h005 is 8'hA0.
- Write: core fills buffer[i]=i[7:0] -> blk_wr -> sd_wr=1. Model acks and issues 512 din strobes -> sd_din sequence 00..FF twice, blk_done, blk_err=0.
- Short transfer: ack then 100 dout strobes, ack falls -> blk_done with blk_err=1.
- Timeout: TIMEOUT=16, no ack -> sd_rd drops after 16 cycles, blk_err=1, blk_done pulses.
- Protection and stale ack: core_we to addr 0 during XFER -> buffer[0] unchanged. sd_ack held high before request -> FSM stays in REQ until ack goes low then high.
- Reset mid-XFER: after 200 strobes -> all outputs 0, no blk_done. A subsequent blk_rd completes normally.
